// File: rtl/parameterized_set_assoc_cache.sv
// parameterized_set_assoc_cache
//   Two-way set-associative, write-back, write-allocate word cache between the
//   CPU and the RAM controller. One outstanding CPU request at a time.
//
//   Optional feature macro: CACHE_STATS_EN (adds hit_count / miss_count ports).
//
// Handshakes (one description for all of them):
//   CPU side : req is sampled at a rising clka edge only while busy=0. The
//              answer is a one-cycle ack pulse. hit and douta are valid with
//              ack and hold until the next ack. A new req may be presented in
//              the ack cycle itself.
//   RAM side : fetch/flush are levels held with a stable address/data until
//              the matching fetch_ack/flush_ack is sampled high at a rising
//              edge. The request drops the cycle after the ack.
//
// Ports:
//   clka, rsta         clock, synchronous active-high reset
//   req, wea           CPU request strobe, 1=write 0=read
//   addra, dina        CPU word address, CPU write data
//   douta, ack, hit    read data, completion pulse, 1=served from cache
//   busy               miss in progress (req ignored)
//   fetch, fetch_addr  RAM read request and word address
//   fetch_ack, mem_din RAM read data valid, RAM read data
//   flush, flush_addr, flush_data  victim write-back request
//   flush_ack          RAM accepted the write-back
//   hit_count, miss_count  (CACHE_STATS_EN only) wrapping ack counters
module parameterized_set_assoc_cache #(
  parameter int ADDRESS_SPACE = 12,
  parameter int DATA_SIZE     = 32,
  parameter int INDEX_BITS    = 9,
  parameter int TAG_BITS      = ADDRESS_SPACE - INDEX_BITS
) (
  input  logic                     clka,
  input  logic                     rsta,
  input  logic                     req,
  input  logic                     wea,
  input  logic [ADDRESS_SPACE-1:0] addra,
  input  logic [DATA_SIZE-1:0]     dina,
  output logic [DATA_SIZE-1:0]     douta,
  output logic                     ack,
  output logic                     hit,
  output logic                     busy,
  output logic                     fetch,
  output logic [ADDRESS_SPACE-1:0] fetch_addr,
  input  logic                     fetch_ack,
  input  logic [DATA_SIZE-1:0]     mem_din,
  output logic                     flush,
  output logic [ADDRESS_SPACE-1:0] flush_addr,
  output logic [DATA_SIZE-1:0]     flush_data,
  input  logic                     flush_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]              hit_count,
  output logic [31:0]              miss_count
`endif
);

  localparam int SETS = 2 ** INDEX_BITS;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_FETCH = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Per-way storage. valid/dirty/lru are reset; tag/data are not.
  logic [SETS-1:0]      valid_q [2];
  logic [SETS-1:0]      dirty_q [2];
  logic [SETS-1:0]      lru_q;
  logic [TAG_BITS-1:0]  tag_mem  [2][SETS];
  logic [DATA_SIZE-1:0] data_mem [2][SETS];

  // Miss context captured when the request is accepted.
  logic [ADDRESS_SPACE-1:0] lat_addr;
  logic                     lat_we;
  logic [DATA_SIZE-1:0]     lat_din;
  logic                     lat_way;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag_in;
  logic [INDEX_BITS-1:0] lat_idx;
  logic                  match0, match1, is_hit, hit_way;
  logic                  victim, victim_dirty;
  logic                  accept;
  logic                  fill;
  logic                  hit_write;

  always_comb begin
    idx          = addra[INDEX_BITS-1:0];
    tag_in       = addra[ADDRESS_SPACE-1:INDEX_BITS];
    lat_idx      = lat_addr[INDEX_BITS-1:0];
    match0       = valid_q[0][idx] && (tag_mem[0][idx] == tag_in);
    match1       = valid_q[1][idx] && (tag_mem[1][idx] == tag_in);
    is_hit       = match0 || match1;
    hit_way      = match1;
    // An empty way is always preferred (way0 first) so a dirty line is never
    // evicted while the set still has room.
    if (!valid_q[0][idx])      victim = 1'b0;
    else if (!valid_q[1][idx]) victim = 1'b1;
    else                       victim = lru_q[idx];
    victim_dirty = valid_q[victim][idx] && dirty_q[victim][idx];
    accept       = (state_q == S_IDLE) && req;
    hit_write    = accept && is_hit && wea;
    fill         = (state_q == S_FETCH) && fetch_ack;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && !is_hit) state_d = victim_dirty ? S_FLUSH : S_FETCH;
      S_FLUSH: if (flush_ack) state_d = S_FETCH;
      S_FETCH: if (fetch_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clka) begin
    if (rsta) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  assign busy = (state_q != S_IDLE);

  // Control bits, handshake outputs and miss context.
  always_ff @(posedge clka) begin
    if (rsta) begin
      valid_q[0] <= '0;
      valid_q[1] <= '0;
      dirty_q[0] <= '0;
      dirty_q[1] <= '0;
      lru_q      <= '0;
      ack        <= 1'b0;
      hit        <= 1'b0;
      douta      <= '0;
      fetch      <= 1'b0;
      fetch_addr <= '0;
      flush      <= 1'b0;
      flush_addr <= '0;
      flush_data <= '0;
      lat_addr   <= '0;
      lat_we     <= 1'b0;
      lat_din    <= '0;
      lat_way    <= 1'b0;
`ifdef CACHE_STATS_EN
      hit_count  <= '0;
      miss_count <= '0;
`endif
    end else begin
      ack <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (is_hit) begin
              ack          <= 1'b1;
              hit          <= 1'b1;
              douta        <= wea ? dina : data_mem[hit_way][idx];
              lru_q[idx]   <= ~hit_way;
              if (wea) dirty_q[hit_way][idx] <= 1'b1;
`ifdef CACHE_STATS_EN
              hit_count    <= hit_count + 32'd1;
`endif
            end else begin
              lat_addr <= addra;
              lat_we   <= wea;
              lat_din  <= dina;
              lat_way  <= victim;
              if (victim_dirty) begin
                flush      <= 1'b1;
                flush_addr <= {tag_mem[victim][idx], idx};
                flush_data <= data_mem[victim][idx];
              end else begin
                fetch      <= 1'b1;
                fetch_addr <= addra;
              end
            end
          end
        end
        S_FLUSH: begin
          if (flush_ack) begin
            flush                    <= 1'b0;
            dirty_q[lat_way][lat_idx] <= 1'b0;
            fetch                    <= 1'b1;
            fetch_addr               <= lat_addr;
          end
        end
        S_FETCH: begin
          if (fetch_ack) begin
            fetch                     <= 1'b0;
            valid_q[lat_way][lat_idx] <= 1'b1;
            dirty_q[lat_way][lat_idx] <= lat_we;
            lru_q[lat_idx]            <= ~lat_way;
            ack                       <= 1'b1;
            hit                       <= 1'b0;
            douta                     <= lat_we ? lat_din : mem_din;
`ifdef CACHE_STATS_EN
            miss_count                <= miss_count + 32'd1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  // Tag/data arrays: no reset, writes suppressed while rsta is high so an
  // abandoned miss never lands in the array.
  always_ff @(posedge clka) begin
    if (!rsta) begin
      if (hit_write) data_mem[hit_way][idx] <= dina;
      if (fill) begin
        tag_mem[lat_way][lat_idx]  <= lat_addr[ADDRESS_SPACE-1:INDEX_BITS];
        data_mem[lat_way][lat_idx] <= lat_we ? lat_din : mem_din;
      end
    end
  end

endmodule

// File: tb/tb_parameterized_set_assoc_cache.sv
module tb_parameterized_set_assoc_cache;

  localparam int AW   = 12;
  localparam int DW   = 32;
  localparam int IW   = 9;
  localparam int TW   = AW - IW;
  localparam int SETS = 2 ** IW;

  // ---------------- clock / reset / DUT ----------------
  logic          clka = 1'b0;
  logic          rsta = 1'b1;
  logic          req = 1'b0, wea = 1'b0;
  logic [AW-1:0] addra = '0;
  logic [DW-1:0] dina = '0;
  logic [DW-1:0] douta;
  logic          ack, hit, busy, fetch, flush;
  logic [AW-1:0] fetch_addr, flush_addr;
  logic [DW-1:0] flush_data;
  logic          fetch_ack = 1'b0, flush_ack = 1'b0;
  logic [DW-1:0] mem_din = '0;
`ifdef CACHE_STATS_EN
  logic [31:0]   hit_count, miss_count;
`endif

  always #5 clka = ~clka;

  parameterized_set_assoc_cache #(
    .ADDRESS_SPACE(AW), .DATA_SIZE(DW), .INDEX_BITS(IW)
  ) dut (
    .clka(clka), .rsta(rsta), .req(req), .wea(wea), .addra(addra), .dina(dina),
    .douta(douta), .ack(ack), .hit(hit), .busy(busy),
    .fetch(fetch), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack), .mem_din(mem_din),
    .flush(flush), .flush_addr(flush_addr), .flush_data(flush_data), .flush_ack(flush_ack)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  // ---------------- reference model ----------------
  // Main memory as a flat array; each set as a recency list of at most two
  // lines, position 0 = most recently used, position 1 = LRU.
  logic [DW-1:0] mem [SETS*8];
  int            m_cnt   [SETS];
  logic [TW-1:0] m_tag   [SETS][2];
  logic [DW-1:0] m_data  [SETS][2];
  logic          m_dirty [SETS][2];

  int checks = 0;
  int errors = 0;

  logic          seen_flush;
  logic [AW-1:0] seen_flush_addr;
  logic [DW-1:0] seen_flush_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < SETS; s++) m_cnt[s] = 0;
  endtask

  function automatic int model_find(input int s, input logic [TW-1:0] t);
    for (int p = 0; p < m_cnt[s]; p++) if (m_tag[s][p] == t) return p;
    return -1;
  endfunction

  // Move a line to the MRU position.
  task automatic model_touch(input int s, input int p);
    logic [TW-1:0] t; logic [DW-1:0] d; logic y;
    t = m_tag[s][p]; d = m_data[s][p]; y = m_dirty[s][p];
    if (p == 1) begin
      m_tag[s][1] = m_tag[s][0]; m_data[s][1] = m_data[s][0]; m_dirty[s][1] = m_dirty[s][0];
    end
    m_tag[s][0] = t; m_data[s][0] = d; m_dirty[s][0] = y;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clka); #1;
    end
  endtask

  // ---------------- driver + checker for one CPU access ----------------
  task automatic do_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input bit poke_busy);
    logic [IW-1:0] ix;
    logic [TW-1:0] t;
    logic [DW-1:0] exp_d;
    logic [AW-1:0] vaddr;
    int s, p, n;
    ix = a[IW-1:0]; t = a[AW-1:IW]; s = int'(ix);
    p = model_find(s, t);
    seen_flush = 1'b0;
    req = 1'b1; wea = we; addra = a; dina = d;
    @(posedge clka); #1;
    req = 1'b0;
    if (p >= 0) begin
      exp_d = we ? d : m_data[s][p];
      chk("hit_ack", ack, 1); chk("hit_flag", hit, 1);
      chk("hit_douta", douta, exp_d); chk("hit_busy", busy, 0);
      model_touch(s, p);
      if (we) begin m_data[s][0] = d; m_dirty[s][0] = 1'b1; end
    end else begin
      chk("miss_busy", busy, 1); chk("miss_noack", ack, 0);
      if (m_cnt[s] == 2 && m_dirty[s][1]) begin
        vaddr = {m_tag[s][1], ix};
        chk("flush_req", flush, 1); chk("flush_addr", flush_addr, vaddr);
        chk("flush_data", flush_data, m_data[s][1]); chk("flush_nofetch", fetch, 0);
        seen_flush = 1'b1; seen_flush_addr = flush_addr; seen_flush_data = flush_data;
        n = $urandom_range(0, 3);
        for (int i = 0; i < n; i++) begin
          fetch_ack = 1'($urandom_range(0, 1));   // must be ignored here
          @(posedge clka); #1;
        end
        chk("flush_hold", flush, 1); chk("flush_hold_addr", flush_addr, vaddr);
        fetch_ack = 1'b0; flush_ack = 1'b1;
        @(posedge clka); #1;
        flush_ack = 1'b0;
        mem[vaddr] = m_data[s][1];
        chk("flush_drop", flush, 0);
      end else begin
        chk("miss_noflush", flush, 0);
      end
      chk("fetch_req", fetch, 1); chk("fetch_addr", fetch_addr, a);
      if (poke_busy) begin
        req = 1'b1; wea = 1'b0; addra = a ^ 12'h801;
        @(posedge clka); #1;
        req = 1'b0;
        chk("busy_ignore_ack", ack, 0); chk("busy_ignore_addr", fetch_addr, a);
      end
      n = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) begin
        flush_ack = 1'($urandom_range(0, 1));     // must be ignored here
        @(posedge clka); #1;
      end
      chk("fetch_hold", fetch, 1);
      flush_ack = 1'b0; fetch_ack = 1'b1; mem_din = mem[a];
      @(posedge clka); #1;
      fetch_ack = 1'b0; mem_din = $urandom;
      exp_d = we ? d : mem[a];
      chk("miss_ack", ack, 1); chk("miss_flag", hit, 0); chk("miss_douta", douta, exp_d);
      chk("miss_busy_clr", busy, 0); chk("miss_fetch_drop", fetch, 0);
      // Insert as MRU, dropping the LRU line if the set was full.
      if (m_cnt[s] < 2) m_cnt[s]++;
      m_tag[s][1] = m_tag[s][0]; m_data[s][1] = m_data[s][0]; m_dirty[s][1] = m_dirty[s][0];
      m_tag[s][0] = t; m_data[s][0] = exp_d; m_dirty[s][0] = we;
    end
  endtask

  task automatic do_reset();
    rsta = 1'b1;
    @(posedge clka); #1;
    rsta = 1'b0;
    model_clear();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    for (int i = 0; i < SETS * 8; i++) mem[i] = $urandom;
    mem[12'h005] = 32'hDEADBEEF;
    model_clear();
    cycles(2);
    rsta = 1'b0;

    chk("rst_ack", ack, 0); chk("rst_hit", hit, 0); chk("rst_busy", busy, 0);
    chk("rst_fetch", fetch, 0); chk("rst_flush", flush, 0); chk("rst_douta", douta, 0);
    chk("rst_fetch_addr", fetch_addr, 0); chk("rst_flush_addr", flush_addr, 0);
    chk("rst_flush_data", flush_data, 0);

    // 1: cold read miss, then hit
    do_op(1'b0, 12'h005, '0, 1'b0);
    chk("t1_miss_dout", douta, 32'hDEADBEEF);
    do_op(1'b0, 12'h005, '0, 1'b0);
    chk("t1_hit", hit, 1); chk("t1_hit_dout", douta, 32'hDEADBEEF);
    cycles(1);
    chk("t1_ack_pulse", ack, 0); chk("t1_hit_hold", hit, 1);
    chk("t1_dout_hold", douta, 32'hDEADBEEF);

    // 2: write hit, fill way1, dirty eviction of 0x005
    do_op(1'b1, 12'h005, 32'h11111111, 1'b0);
    chk("t2_wr_hit", hit, 1);
    do_op(1'b0, 12'h205, '0, 1'b0);
    chk("t2_no_flush", seen_flush, 0);
    do_op(1'b0, 12'h405, '0, 1'b0);
    chk("t2_flush_seen", seen_flush, 1);
    chk("t2_flush_addr", seen_flush_addr, 12'h005);
    chk("t2_flush_data", seen_flush_data, 32'h11111111);

    // 3: write miss then read hit
    do_op(1'b1, 12'h010, 32'hCAFEF00D, 1'b0);
    chk("t3_wmiss_hit", hit, 0); chk("t3_wmiss_dout", douta, 32'hCAFEF00D);
    do_op(1'b0, 12'h010, '0, 1'b0);
    chk("t3_rd_hit", hit, 1); chk("t3_rd_dout", douta, 32'hCAFEF00D);

    // 5: req during busy is ignored
    do_op(1'b0, 12'h0AC, '0, 1'b1);
    cycles(1);
    chk("t5_no_extra_ack", ack, 0);

    // 4: reset mid-fetch abandons the miss and clears valid bits
    req = 1'b1; wea = 1'b0; addra = 12'h0AB;
    @(posedge clka); #1;
    req = 1'b0;
    chk("t4_fetch_up", fetch, 1);
    do_reset();
    chk("t4_fetch_drop", fetch, 0); chk("t4_busy_drop", busy, 0); chk("t4_no_ack", ack, 0);
    do_op(1'b0, 12'h405, '0, 1'b0);
    chk("t4_after_rst_miss", hit, 0);

    // random traffic on a few conflicting sets
    for (int k = 0; k < 300; k++) begin
      logic [AW-1:0] a;
      a = AW'((32'($urandom_range(0, 7)) << IW) | 32'($urandom_range(0, 3)));
      do_op(1'($urandom_range(0, 1)), a, $urandom, ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 3) == 0) cycles($urandom_range(1, 2));
    end

`ifdef CACHE_STATS_EN
    do_reset();
    chk("st_rst_hits0", hit_count, 0); chk("st_rst_miss0", miss_count, 0);
    do_op(1'b0, 12'h005, '0, 1'b0);
    do_op(1'b0, 12'h005, '0, 1'b0);
    chk("st_hits", hit_count, 1); chk("st_misses", miss_count, 1);
    do_reset();
    chk("st_clr_hits", hit_count, 0); chk("st_clr_misses", miss_count, 0);
`endif

    cycles(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
